// File: rtl/decode_pkg.sv
// Shared encodings and the ID/EX record for the 20-bit-instruction decode stage.
// Record fields are sized for the widest supported configuration; the top uses the low bits.
package decode_pkg;

  localparam logic [1:0] CLS_RALU = 2'b00;
  localparam logic [1:0] CLS_IALU = 2'b01;
  localparam logic [1:0] CLS_MEM  = 2'b10;
  localparam logic [1:0] CLS_CTRL = 2'b11;

  localparam logic [1:0] CTL_JUMP = 2'b00;
  localparam logic [1:0] CTL_BEQ  = 2'b01;
  localparam logic [1:0] CTL_BNE  = 2'b10;
  localparam logic [1:0] CTL_NOP  = 2'b11;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam int XLEN_MAX = 64;
  localparam int PCW_MAX  = 32;
  localparam int RAW_MAX  = 8;

  typedef struct packed {
    logic                reg_write;
    logic                mem_write;
    logic                jump;
    logic                alu_src;
    logic                result_src;
    logic                cant_byte;
    logic [1:0]          branch;
    logic [2:0]          alu_control;
    logic [XLEN_MAX-1:0] rd1;
    logic [XLEN_MAX-1:0] rd2;
    logic [XLEN_MAX-1:0] imm_ext;
    logic [PCW_MAX-1:0]  pc;
    logic [RAW_MAX-1:0]  rd;
    logic [RAW_MAX-1:0]  rs1;
    logic [RAW_MAX-1:0]  rs2;
  } idex_t;

endpackage

// File: rtl/regfile_p.sv
// Architectural register file: two combinational read ports with write-first bypass,
// one write port; entry 0 and out-of-range indices always read as zero.
module regfile_p #(
  parameter int XLEN = 19,
  parameter int NREG = 19,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_we,
  input  logic [RAW-1:0]  i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [RAW-1:0]  i_ra1,
  input  logic [RAW-1:0]  i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_we_ok;

  assign w_we_ok = i_we && (i_wa != '0) && (32'(i_wa) < NREG);

  // Entry 0 is never written, so it holds the reset value of zero.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_mem[gi] <= '0;
        end else if (w_we_ok && (i_wa == RAW'(gi))) begin
          r_mem[gi] <= i_wd;
        end
      end
    end
  endgenerate

  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    for (int i = 1; i < NREG; i++) begin
      if (i_ra1 == RAW'(i)) o_rd1 = (w_we_ok && i_wa == i_ra1) ? i_wd : r_mem[i];
      if (i_ra2 == RAW'(i)) o_rd2 = (w_we_ok && i_wa == i_ra2) ? i_wd : r_mem[i];
    end
  end

endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: field decode, immediate extension, register read, load-use
// bubble insertion and the ID/EX pipeline register.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int XLEN = 19,
  parameter int PCW  = 15,
  parameter int NREG = 19,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_d,
  input  logic            flush_e,
  input  logic [19:0]     instr_d,
  input  logic [PCW-1:0]  pc_d,
  input  logic            reg_write_w,
  input  logic [RAW-1:0]  rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic            lu_stall,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            jump_e,
  output logic            alu_src_e,
  output logic            result_src_e,
  output logic            cant_byte_e,
  output logic [1:0]      branch_e,
  output logic [2:0]      alu_control_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [PCW-1:0]  pc_e,
  output logic [RAW-1:0]  rd_e,
  output logic [RAW-1:0]  rs1_e,
  output logic [RAW-1:0]  rs2_e
);

  idex_t           r_idex;
  idex_t           w_dec;
  logic [4:0]      w_opcode;
  logic [RAW-1:0]  w_rd;
  logic [RAW-1:0]  w_rs1;
  logic [RAW-1:0]  w_rs2;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic [XLEN-1:0] w_imm_lo;
  logic [XLEN-1:0] w_imm_hi;
  logic [XLEN-1:0] w_imm_jmp;
  logic            w_unused_idex;

  assign w_opcode  = instr_d[19:15];
  assign w_rd      = RAW'(instr_d[14:10]);
  assign w_rs1     = RAW'(instr_d[9:5]);
  assign w_rs2     = RAW'(instr_d[4:0]);
  assign w_imm_lo  = XLEN'($signed(instr_d[4:0]));
  assign w_imm_hi  = XLEN'($signed(instr_d[14:10]));
  assign w_imm_jmp = XLEN'($signed(instr_d[14:0]));

  regfile_p #(.XLEN(XLEN), .NREG(NREG), .RAW(RAW)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .i_we  (reg_write_w),
    .i_wa  (rd_w),
    .i_wd  (result_w),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  always_comb begin
    w_dec     = '0;
    w_dec.rd  = RAW_MAX'(w_rd);
    w_dec.rs1 = RAW_MAX'(w_rs1);
    w_dec.rs2 = RAW_MAX'(w_rs2);
    w_dec.rd1 = XLEN_MAX'(w_rd1);
    w_dec.rd2 = XLEN_MAX'(w_rd2);
    w_dec.pc  = PCW_MAX'(pc_d);
    case (w_opcode[4:3])
      CLS_RALU: begin
        w_dec.reg_write   = 1'b1;
        w_dec.alu_control = w_opcode[2:0];
      end
      CLS_IALU: begin
        w_dec.reg_write   = 1'b1;
        w_dec.alu_src     = 1'b1;
        w_dec.alu_control = w_opcode[2:0];
        w_dec.imm_ext     = XLEN_MAX'(w_imm_lo);
      end
      CLS_MEM: begin
        w_dec.alu_src     = 1'b1;
        w_dec.alu_control = ALU_ADD;
        w_dec.cant_byte   = w_opcode[0];
        if (!w_opcode[2]) begin
          w_dec.reg_write  = 1'b1;
          w_dec.result_src = 1'b1;
          w_dec.imm_ext    = XLEN_MAX'(w_imm_lo);
        end else begin
          w_dec.mem_write  = 1'b1;
          w_dec.imm_ext    = XLEN_MAX'(w_imm_hi);
        end
      end
      default: begin
        case (w_opcode[2:1])
          CTL_JUMP: begin
            w_dec.jump    = 1'b1;
            w_dec.imm_ext = XLEN_MAX'(w_imm_jmp);
          end
          CTL_BEQ, CTL_BNE: begin
            w_dec.branch      = (w_opcode[2:1] == CTL_BEQ) ? BR_EQ : BR_NE;
            w_dec.alu_control = ALU_SUB;
            w_dec.imm_ext     = XLEN_MAX'(w_imm_hi);
          end
          default: w_dec.branch = BR_NONE;
        endcase
      end
    endcase
  end

  // A load in EX whose destination feeds this instruction must wait one cycle.
  assign lu_stall = r_idex.result_src && r_idex.reg_write && (rd_e != '0)
                    && ((rd_e == w_rs1) || (rd_e == w_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idex <= '0;
    end else if (flush_e) begin
      r_idex <= '0;
    end else if (!stall_d) begin
      r_idex <= lu_stall ? '0 : w_dec;
    end
  end

  assign reg_write_e   = r_idex.reg_write;
  assign mem_write_e   = r_idex.mem_write;
  assign jump_e        = r_idex.jump;
  assign alu_src_e     = r_idex.alu_src;
  assign result_src_e  = r_idex.result_src;
  assign cant_byte_e   = r_idex.cant_byte;
  assign branch_e      = r_idex.branch;
  assign alu_control_e = r_idex.alu_control;
  assign rd1_e         = r_idex.rd1[XLEN-1:0];
  assign rd2_e         = r_idex.rd2[XLEN-1:0];
  assign imm_ext_e     = r_idex.imm_ext[XLEN-1:0];
  assign pc_e          = r_idex.pc[PCW-1:0];
  assign rd_e          = r_idex.rd[RAW-1:0];
  assign rs1_e         = r_idex.rs1[RAW-1:0];
  assign rs2_e         = r_idex.rs2[RAW-1:0];

  // Upper bits of the wide record are constant zero in this configuration.
  assign w_unused_idex = ^r_idex;

endmodule

// File: tb/tb_decode_stage_p.sv
// Self-checking bench for decode_stage_p: directed plan steps, then randomized
// traffic checked against an arithmetic model of the decode rules.
module tb_decode_stage_p;

  localparam int XLEN = 19;
  localparam int PCW  = 15;
  localparam int NREG = 19;
  localparam int RAW  = 5;
  localparam longint XMASK = (longint'(1) << XLEN) - 1;

  logic            clk = 1'b0;
  logic            reset, stall_d, flush_e, reg_write_w;
  logic [19:0]     instr_d;
  logic [PCW-1:0]  pc_d;
  logic [RAW-1:0]  rd_w;
  logic [XLEN-1:0] result_w;
  logic            lu_stall, reg_write_e, mem_write_e, jump_e, alu_src_e, result_src_e, cant_byte_e;
  logic [1:0]      branch_e;
  logic [2:0]      alu_control_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_ext_e;
  logic [PCW-1:0]  pc_e;
  logic [RAW-1:0]  rd_e, rs1_e, rs2_e;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit rw, mw, j, as, rs, cb;
    int br, alu;
    longint rd1, rd2, imm, pc;
    int rd, rs1, rs2;
  } exp_t;

  exp_t   m_cur;
  longint m_regs [NREG];

  decode_stage_p #(.XLEN(XLEN), .PCW(PCW), .NREG(NREG), .RAW(RAW)) dut (
    .clk(clk), .reset(reset), .stall_d(stall_d), .flush_e(flush_e),
    .instr_d(instr_d), .pc_d(pc_d), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_w(result_w), .lu_stall(lu_stall), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .jump_e(jump_e), .alu_src_e(alu_src_e),
    .result_src_e(result_src_e), .cant_byte_e(cant_byte_e), .branch_e(branch_e),
    .alu_control_e(alu_control_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_ext_e(imm_ext_e), .pc_e(pc_e), .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e)
  );

  always #5 clk = ~clk;

  function automatic exp_t zero_exp();
    exp_t e;
    e.rw = 0; e.mw = 0; e.j = 0; e.as = 0; e.rs = 0; e.cb = 0;
    e.br = 0; e.alu = 0; e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.pc = 0;
    e.rd = 0; e.rs1 = 0; e.rs2 = 0;
    return e;
  endfunction

  // Two's-complement value of an n-bit field, reduced to XLEN bits.
  function automatic longint sx(input longint v, input int n);
    longint s = v;
    if (v >= (longint'(1) << (n - 1))) s = v - (longint'(1) << n);
    return s & XMASK;
  endfunction

  function automatic bit wb_hits(input int idx);
    return reg_write_w && rd_w != 0 && int'(rd_w) < NREG && int'(rd_w) == idx;
  endfunction

  function automatic longint rf_read(input int idx);
    if (idx == 0 || idx >= NREG) return 0;
    if (wb_hits(idx)) return longint'(result_w);
    return m_regs[idx];
  endfunction

  function automatic exp_t model_decode(input int instr, input int pc);
    exp_t e = zero_exp();
    int op  = instr / 32768;
    int cls = op / 8;
    int sub = op % 8;
    e.rd  = (instr / 1024) % 32;
    e.rs1 = (instr / 32) % 32;
    e.rs2 = instr % 32;
    e.pc  = pc;
    e.rd1 = rf_read(e.rs1);
    e.rd2 = rf_read(e.rs2);
    if (cls == 0) begin
      e.rw = 1; e.alu = sub;
    end else if (cls == 1) begin
      e.rw = 1; e.as = 1; e.alu = sub; e.imm = sx(e.rs2, 5);
    end else if (cls == 2) begin
      e.as = 1; e.cb = sub % 2;
      if (sub < 4) begin e.rw = 1; e.rs = 1; e.imm = sx(e.rs2, 5); end
      else begin e.mw = 1; e.imm = sx(e.rd, 5); end
    end else begin
      if (sub / 2 == 0) begin e.j = 1; e.imm = sx(instr % 32768, 15); end
      else if (sub / 2 == 1) begin e.br = 1; e.alu = 1; e.imm = sx(e.rd, 5); end
      else if (sub / 2 == 2) begin e.br = 2; e.alu = 1; e.imm = sx(e.rd, 5); end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".reg_write_e"},   64'(reg_write_e),   64'(m_cur.rw));
    check({tag, ".mem_write_e"},   64'(mem_write_e),   64'(m_cur.mw));
    check({tag, ".jump_e"},        64'(jump_e),        64'(m_cur.j));
    check({tag, ".alu_src_e"},     64'(alu_src_e),     64'(m_cur.as));
    check({tag, ".result_src_e"},  64'(result_src_e),  64'(m_cur.rs));
    check({tag, ".cant_byte_e"},   64'(cant_byte_e),   64'(m_cur.cb));
    check({tag, ".branch_e"},      64'(branch_e),      64'(m_cur.br));
    check({tag, ".alu_control_e"}, 64'(alu_control_e), 64'(m_cur.alu));
    check({tag, ".rd1_e"},         64'(rd1_e),         64'(m_cur.rd1));
    check({tag, ".rd2_e"},         64'(rd2_e),         64'(m_cur.rd2));
    check({tag, ".imm_ext_e"},     64'(imm_ext_e),     64'(m_cur.imm));
    check({tag, ".pc_e"},          64'(pc_e),          64'(m_cur.pc));
    check({tag, ".rd_e"},          64'(rd_e),          64'(m_cur.rd));
    check({tag, ".rs1_e"},         64'(rs1_e),         64'(m_cur.rs1));
    check({tag, ".rs2_e"},         64'(rs2_e),         64'(m_cur.rs2));
  endtask

  task automatic drive(input logic [19:0] ins, input logic st, input logic fl,
                       input logic we, input logic [RAW-1:0] wa, input logic [XLEN-1:0] wd);
    instr_d = ins; stall_d = st; flush_e = fl;
    reg_write_w = we; rd_w = wa; result_w = wd;
    pc_d = PCW'($urandom);
  endtask

  // Checks the hazard flag for the current inputs, clocks once, checks ID/EX.
  task automatic step(input string tag);
    exp_t nxt;
    bit   lu;
    int   rs1f, rs2f;
    #1;
    rs1f = (int'(instr_d) / 32) % 32;
    rs2f = int'(instr_d) % 32;
    lu = m_cur.rs && m_cur.rw && m_cur.rd != 0 && (m_cur.rd == rs1f || m_cur.rd == rs2f);
    check({tag, ".lu_stall"}, 64'(lu_stall), 64'(lu));
    if (flush_e)      nxt = zero_exp();
    else if (stall_d) nxt = m_cur;
    else if (lu)      nxt = zero_exp();
    else              nxt = model_decode(int'(instr_d), int'(pc_d));
    if (wb_hits(int'(rd_w))) m_regs[rd_w] = longint'(result_w);
    @(posedge clk);
    #1;
    m_cur = nxt;
    check_outputs(tag);
    $display("[TB] %s instr=0x%05h lu=%0d rd1_e=0x%0h imm_ext_e=0x%0h", tag, instr_d, lu, rd1_e, imm_ext_e);
  endtask

  initial begin
    logic [19:0] ins;
    int          prev_rd;
    m_cur = zero_exp();
    for (int i = 0; i < NREG; i++) m_regs[i] = 0;
    reset = 1'b1;
    drive(20'h0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check_outputs("reset");
    check("reset.lu_stall", 64'(lu_stall), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    drive(20'h00C22, 0, 0, 0, 0, 0);
    step("add");
    check("add.rd_e_const", 64'(rd_e), 64'd3);
    check("add.pc_e_vs_pc_d", 64'(pc_e), 64'(pc_d));

    drive(20'h4101F, 0, 0, 0, 0, 0);
    step("ialu");
    check("ialu.imm_const", 64'(imm_ext_e), 64'h7FFFF);

    drive(20'h00C22, 0, 0, 1, 5'd1, 19'h12345);
    step("bypass");
    check("bypass.rd1_const", 64'(rd1_e), 64'h12345);

    drive(20'h00C02, 0, 0, 1, 5'd0, 19'h55555);
    step("r0_write");
    check("r0_write.rd1_const", 64'(rd1_e), 64'd0);

    drive(20'h81462, 0, 0, 0, 0, 0);
    step("load");
    drive(20'h018A0, 0, 0, 0, 0, 0);
    #1;
    check("loaduse.lu_const", 64'(lu_stall), 64'd1);
    step("loaduse_bubble");
    check("loaduse.bubble_rw", 64'(reg_write_e), 64'd0);
    step("loaduse_issue");
    check("loaduse.rs1_const", 64'(rs1_e), 64'd5);

    drive(20'hD0000, 0, 0, 0, 0, 0);
    step("beq");
    check("beq.branch_const", 64'(branch_e), 64'd1);
    check("beq.alu_const", 64'(alu_control_e), 64'd1);

    drive(20'hC7FFC, 0, 0, 0, 0, 0);
    step("jump");
    check("jump.imm_const", 64'(imm_ext_e), 64'h7FFFC);

    drive(20'h00C22, 1, 1, 0, 0, 0);
    step("flush_stall");
    check("flush_stall.jump_const", 64'(jump_e), 64'd0);

    drive(20'h81462, 0, 0, 0, 0, 0);
    step("load2");
    drive(20'h018A0, 1, 0, 0, 0, 0);
    step("stall_hold");
    #2;
    reset = 1'b1;
    #1;
    m_cur = zero_exp();
    for (int i = 0; i < NREG; i++) m_regs[i] = 0;
    check_outputs("mid_reset");
    check("mid_reset.lu_stall", 64'(lu_stall), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    prev_rd = 0;
    for (int n = 0; n < 400; n++) begin
      ins = 20'($urandom);
      if ($urandom_range(0, 3) == 0) ins[19:16] = 4'b1000;
      if ($urandom_range(0, 2) == 0) ins[9:5] = 5'(prev_rd);
      drive(ins, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            1'($urandom), 5'($urandom), 19'($urandom));
      step($sformatf("rand%0d", n));
      prev_rd = (int'(ins) / 1024) % 32;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
